// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared NoC constants: flit format, credit depth, arbiter states.
// Revision : 1.0
// ============================================================================
package noc_pkg;

    localparam int FLIT_W  = 20;
    localparam int CREDITS = 7;
    localparam int CNT_W   = 3;

    // Flit type lives in the two MSBs of every flit.
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker, first eligible index at or
//            above the pointer with wrap-around.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            if (!o_any) begin
                j = int'(i_ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (i_elig[j]) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IW'(j);
                end
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/pe_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_link_arbiter
// Brief    : Credit-based, packet-atomic round-robin arbiter sharing one
//            router injection link among NREQ local flit sources.
// Revision : 1.0
// ============================================================================
module pe_link_arbiter #(
    parameter int NREQ    = 4,
    parameter int FLIT_W  = noc_pkg::FLIT_W,
    parameter int CREDITS = noc_pkg::CREDITS,
    parameter int CNT_W   = noc_pkg::CNT_W,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FLIT_W-1:0] req_flit,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   ci,
    output logic [FLIT_W-1:0]      out_flit,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       credit_cnt,
    output logic [IDW-1:0]         grant_id,
    output logic                   locked,
    output logic                   credit_err
);

    import noc_pkg::*;

    arb_state_t          r_state;
    arb_state_t          w_state_n;
    logic [IDW-1:0]      r_rr;
    logic [IDW-1:0]      w_rr_n;
    logic [IDW-1:0]      r_gid;
    logic [IDW-1:0]      w_gid_n;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [FLIT_W-1:0]   r_flit;
    logic                r_oval;

    logic [1:0]          w_ft [NREQ];
    logic [NREQ-1:0]     w_elig;
    logic [NREQ-1:0]     w_pick_grant;
    logic [IDW-1:0]      w_pick_idx;
    logic                w_pick_any;
    logic                w_has_credit;
    logic                w_send;
    logic [IDW-1:0]      w_sel;
    logic [FLIT_W-1:0]   w_sel_flit;
    logic [1:0]          w_sel_ft;

    function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] x);
        return (x == IDW'(NREQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // Only packet starts may win a fresh arbitration.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
            assign w_ft[gi]   = req_flit[gi*FLIT_W + FLIT_W - 2 +: 2];
            assign w_elig[gi] = req_valid[gi] &&
                                ((w_ft[gi] == FT_HEAD) || (w_ft[gi] == FT_SINGLE));
        end
    endgenerate

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_rr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_has_credit = (r_cnt != '0);
    assign w_sel        = (r_state == LOCKED) ? r_gid : w_pick_idx;
    assign w_sel_flit   = req_flit[w_sel*FLIT_W +: FLIT_W];
    assign w_sel_ft     = w_sel_flit[FLIT_W-1:FLIT_W-2];

    always_comb begin
        req_ready = '0;
        w_send    = 1'b0;
        w_state_n = r_state;
        w_rr_n    = r_rr;
        w_gid_n   = r_gid;
        case (r_state)
            IDLE: begin
                if (w_pick_any && w_has_credit) begin
                    req_ready = w_pick_grant;
                    w_send    = 1'b1;
                    w_gid_n   = w_pick_idx;
                    if (w_sel_ft == FT_SINGLE) begin
                        w_rr_n = f_inc(w_pick_idx);
                    end else begin
                        w_state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Heads and singles mid-packet pass through; only a tail unlocks.
                if (req_valid[r_gid] && w_has_credit) begin
                    req_ready[r_gid] = 1'b1;
                    w_send           = 1'b1;
                    if (w_sel_ft == FT_TAIL) begin
                        w_state_n = IDLE;
                        w_rr_n    = f_inc(r_gid);
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_gid   <= '0;
            r_cnt   <= CNT_W'(CREDITS);
            r_err   <= 1'b0;
            r_flit  <= '0;
            r_oval  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_rr    <= w_rr_n;
            r_gid   <= w_gid_n;
            r_oval  <= w_send;
            if (w_send) begin
                r_flit <= w_sel_flit;
            end
            if (w_send && !ci) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (!w_send && ci) begin
                if (r_cnt == CNT_W'(CREDITS)) begin
                    r_err <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_flit   = r_flit;
    assign out_valid  = r_oval;
    assign credit_cnt = r_cnt;
    assign grant_id   = r_gid;
    assign locked     = (r_state == LOCKED);
    assign credit_err = r_err;

endmodule : pe_link_arbiter
`default_nettype wire

// File: tb/tb_pe_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_link_arbiter
// Brief    : Randomized and directed bench for pe_link_arbiter against a
//            queue-based behavioural model of the link.
// Revision : 1.0
// ============================================================================
module tb_pe_link_arbiter;

    import noc_pkg::*;

    localparam int N  = 4;
    localparam int FW = 20;
    localparam int CR = 7;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*FW-1:0] req_flit;
    logic [N-1:0]    req_ready;
    logic            ci;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic [CW-1:0]   credit_cnt;
    logic [1:0]      grant_id;
    logic            locked;
    logic            credit_err;

    always #5 clk = ~clk;

    pe_link_arbiter #(
        .NREQ    (N),
        .FLIT_W  (FW),
        .CREDITS (CR),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_flit   (req_flit),
        .req_ready  (req_ready),
        .ci         (ci),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .credit_cnt (credit_cnt),
        .grant_id   (grant_id),
        .locked     (locked),
        .credit_err (credit_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model of the link as seen from outside.
    int            m_cnt, m_err, m_locked, m_gid, m_rr, m_oval;
    logic [FW-1:0] m_oflit;
    logic [N-1:0]  m_exp;

    logic [FW-1:0] q [N][$];
    logic [FW-1:0] obs_q [$];
    int            sent;
    int            bub_pct = 0;
    logic [N-1:0]  obs_ready;
    int            obs_cnt, obs_locked, obs_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ftype(input logic [FW-1:0] f);
        return f[FW-1:FW-2];
    endfunction

    function automatic logic [FW-1:0] mk(input logic [1:0] t);
        return {t, 18'($urandom)};
    endfunction

    task automatic model_reset();
        m_cnt    = CR;
        m_err    = 0;
        m_locked = 0;
        m_gid    = 0;
        m_rr     = 0;
        m_oval   = 0;
        m_oflit  = '0;
    endtask

    function automatic logic [N-1:0] predict(input logic [N-1:0] v, input logic [N*FW-1:0] f);
        logic [N-1:0] r;
        r = '0;
        if (m_cnt == 0) return r;
        if (m_locked != 0) begin
            if (v[m_gid]) r[m_gid] = 1'b1;
            return r;
        end
        for (int k = 0; k < N; k++) begin
            int         j;
            logic [1:0] t;
            j = (m_rr + k) % N;
            t = ftype(f[j*FW +: FW]);
            if (v[j] && (t == FT_HEAD || t == FT_SINGLE)) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic check_regs();
        check("out_valid", 32'(out_valid), 32'(m_oval));
        if (m_oval != 0) check("out_flit", 32'(out_flit), 32'(m_oflit));
        check("credit_cnt", 32'(credit_cnt), 32'(m_cnt));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("locked", 32'(locked), 32'(m_locked));
        check("credit_err", 32'(credit_err), 32'(m_err));
    endtask

    task automatic gen_packet(input int i);
        int len;
        len = $urandom_range(1, 4);
        if (len == 1) begin
            q[i].push_back(mk(FT_SINGLE));
        end else begin
            q[i].push_back(mk(FT_HEAD));
            repeat (len - 2) q[i].push_back(mk(FT_BODY));
            q[i].push_back(mk(FT_TAIL));
        end
    endtask

    // ci_mode: 0 none, 1 pulse, 2 on every send, 3 random while credits are out.
    task automatic cyc(input int ci_mode);
        logic [N-1:0]    v;
        logic [N*FW-1:0] f;
        logic            c;
        int              j;
        @(negedge clk);
        v = '0;
        f = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                f[i*FW +: FW] = q[i][0];
                v[i] = ($urandom_range(99) >= bub_pct);
            end
        end
        m_exp = predict(v, f);
        case (ci_mode)
            0:       c = 1'b0;
            1:       c = 1'b1;
            2:       c = (m_exp != '0);
            default: c = (m_cnt < CR) && ($urandom_range(2) == 0);
        endcase
        req_valid = v;
        req_flit  = f;
        ci        = c;
        #1;
        obs_ready  = req_ready;
        obs_cnt    = int'(credit_cnt);
        obs_locked = int'(locked);
        obs_err    = int'(credit_err);
        if (out_valid) obs_q.push_back(out_flit);
        check("req_ready", 32'(req_ready), 32'(m_exp));
        check_regs();
        @(posedge clk);
        if (m_exp != '0) begin
            j = 0;
            for (int i = 0; i < N; i++) if (m_exp[i]) j = i;
            m_oflit = f[j*FW +: FW];
            m_oval  = 1;
            if (m_locked == 0) begin
                m_gid = j;
                if (ftype(m_oflit) == FT_SINGLE) m_rr = (j + 1) % N;
                else                             m_locked = 1;
            end else if (ftype(m_oflit) == FT_TAIL) begin
                m_locked = 0;
                m_rr     = (m_gid + 1) % N;
            end
            void'(q[j].pop_front());
            sent++;
            if (!c) m_cnt--;
        end else begin
            m_oval = 0;
            if (c) begin
                if (m_cnt == CR) m_err = 1;
                else             m_cnt++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst       = 1'b0;
        req_valid = '0;
        ci        = 1'b0;
        #1;
        model_reset();
        check_regs();
        for (int i = 0; i < N; i++) q[i].delete();
        obs_q.delete();
        sent = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [FW-1:0] exp_q [$];
    int            c4;

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_flit  = '0;
        ci        = 1'b0;
        sent      = 0;
        model_reset();
        do_reset();

        // Two single flits from sources 0 and 2, then pointer lands on 3.
        q[0].push_back({FT_SINGLE, 18'h0ABCD});
        q[2].push_back({FT_SINGLE, 18'h2ABCD});
        repeat (3) cyc(0);
        check("t1_cnt", 32'(obs_cnt), 32'd5);
        check("t1_sent", 32'(sent), 32'd2);
        q[0].push_back(mk(FT_SINGLE));
        q[3].push_back(mk(FT_SINGLE));
        cyc(0);
        check("t1_rr_ptr", 32'(obs_ready), 32'b1000);
        cyc(0);
        check("t1_wrap", 32'(obs_ready), 32'b0001);
        cyc(0);

        // Stray body flit while idle is never granted.
        q[1].push_back(mk(FT_BODY));
        c4 = sent;
        repeat (3) cyc(0);
        check("stray_body_ready", 32'(obs_ready), 32'd0);
        check("stray_body_sent", 32'(sent), 32'(c4));
        q[1].delete();

        // Packet atomicity against a waiting single.
        do_reset();
        exp_q.delete();
        q[1].push_back(mk(FT_HEAD)); exp_q.push_back(q[1][0]);
        q[1].push_back(mk(FT_BODY)); exp_q.push_back(q[1][1]);
        q[1].push_back(mk(FT_TAIL)); exp_q.push_back(q[1][2]);
        q[3].push_back(mk(FT_SINGLE)); exp_q.push_back(q[3][0]);
        repeat (6) cyc(0);
        check("t2_count", 32'(obs_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_q.size()) check($sformatf("t2_order%0d", k), 32'(obs_q[k]), 32'(exp_q[k]));
        end

        // Head/single inside a packet does not unlock.
        q[1].push_back(mk(FT_HEAD));
        q[1].push_back(mk(FT_SINGLE));
        q[1].push_back(mk(FT_TAIL));
        cyc(0);
        q[0].push_back(mk(FT_SINGLE));
        cyc(0);
        cyc(0);
        check("t2b_still_locked", 32'(obs_locked), 32'd1);
        repeat (3) cyc(0);

        // Credit exhaustion and single-credit release.
        do_reset();
        q[0].push_back(mk(FT_HEAD));
        repeat (10) q[0].push_back(mk(FT_BODY));
        q[0].push_back(mk(FT_TAIL));
        repeat (9) cyc(0);
        check("t3_cnt_zero", 32'(obs_cnt), 32'd0);
        check("t3_ready_zero", 32'(obs_ready), 32'd0);
        check("t3_sent7", 32'(sent), 32'd7);
        cyc(1);
        cyc(0);
        cyc(0);
        check("t3_sent8", 32'(sent), 32'd8);
        check("t3_stall_again", 32'(obs_ready), 32'd0);
        c4 = 0;
        while ((q[0].size() > 0 || m_locked != 0) && c4 < 100) begin
            cyc(3);
            c4++;
        end
        check("t3_drained", 32'(q[0].size()), 32'd0);

        // Send and credit together keep the stream running.
        do_reset();
        q[2].push_back(mk(FT_HEAD));
        repeat (6) q[2].push_back(mk(FT_BODY));
        q[2].push_back(mk(FT_TAIL));
        c4 = 0;
        while (q[2].size() > 0 && c4 < 20) begin
            cyc(2);
            c4++;
        end
        check("t4_cycles", 32'(c4), 32'd8);
        cyc(0);
        check("t4_cnt", 32'(obs_cnt), 32'd7);

        // Credit overflow is sticky until reset.
        do_reset();
        cyc(1);
        cyc(1);
        cyc(0);
        check("t5_cnt", 32'(obs_cnt), 32'd7);
        check("t5_err", 32'(obs_err), 32'd1);
        repeat (3) cyc(0);
        check("t5_err_sticky", 32'(obs_err), 32'd1);
        do_reset();
        cyc(0);
        check("t5_err_cleared", 32'(obs_err), 32'd0);

        // Reset in the middle of a packet.
        do_reset();
        q[0].push_back(mk(FT_HEAD));
        q[0].push_back(mk(FT_BODY));
        q[0].push_back(mk(FT_BODY));
        q[0].push_back(mk(FT_TAIL));
        cyc(0);
        cyc(0);
        do_reset();
        check("t6_locked", 32'(locked), 32'd0);
        check("t6_cnt", 32'(credit_cnt), 32'd7);
        check("t6_oval", 32'(out_valid), 32'd0);
        q[2].push_back(mk(FT_HEAD));
        q[2].push_back(mk(FT_TAIL));
        cyc(0);
        check("t6_grant2", 32'(obs_ready), 32'b0100);
        repeat (3) cyc(0);

        // Randomized mixed traffic with bubbles and returning credits.
        do_reset();
        bub_pct = 25;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() == 0 && $urandom_range(3) == 0) gen_packet(i);
            end
            cyc(3);
        end
        bub_pct = 0;
        c4 = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_locked != 0)
               && c4 < 400) begin
            cyc(3);
            c4++;
        end
        check("rand_drained", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule : tb_pe_link_arbiter
`default_nettype wire
